// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared state encoding and datapath select constants for mc_decoder
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_RM   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/mc_decoder_alu_dec.sv
// rtl/mc_decoder_alu_dec.sv - combinational ALU control and flag-write decode
module alu_dec
  import mc_pkg::*;
(
  input  logic       ALUOp,
  input  logic [5:0] Funct,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW
);

  // The immediate bit plays no part in ALU selection.
  logic w_unused_imm;
  assign w_unused_imm = Funct[5];

  always_comb begin
    ALUControl = ALU_ADD;
    FlagW      = 2'b00;
    if (ALUOp) begin
      case (Funct[4:1])
        4'b0100: ALUControl = ALU_ADD;
        4'b0010: ALUControl = ALU_SUB;
        4'b0000: ALUControl = ALU_AND;
        4'b1100: ALUControl = ALU_ORR;
        default: ALUControl = ALU_ADD;
      endcase
      // Carry/overflow are only meaningful for arithmetic results.
      FlagW[1] = Funct[0];
      FlagW[0] = Funct[0] & ((ALUControl == ALU_ADD) | (ALUControl == ALU_SUB));
    end
  end

endmodule

// File: rtl/mc_decoder.sv
// rtl/mc_decoder.sv - multicycle Moore control FSM with ALU and PC-write decode
module mc_decoder
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic [1:0] FlagW,
  output logic       NextPC,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [3:0] StateDbg
);

  state_t r_state;
  logic   w_aluop;
  logic   w_branch;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      case (r_state)
        FETCH:  r_state <= DECODE;
        DECODE: begin
          case (Op)
            OP_MEM:  r_state <= MEMADR;
            OP_DP:   r_state <= Funct[5] ? EXECUTEI : EXECUTER;
            OP_BR:   r_state <= BRANCH;
            default: r_state <= UNKNOWN;
          endcase
        end
        MEMADR:   r_state <= Funct[0] ? MEMRD : MEMWR;
        MEMRD:    r_state <= MEMWB;
        EXECUTER: r_state <= ALUWB;
        EXECUTEI: r_state <= ALUWB;
        default:  r_state <= FETCH;
      endcase
    end
  end

  always_comb begin
    NextPC    = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_RM;
    RegW      = 1'b0;
    MemW      = 1'b0;
    w_aluop   = 1'b0;
    w_branch  = 1'b0;
    case (r_state)
      FETCH: begin
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      MEMADR:   ALUSrcB = SRCB_IMM;
      MEMRD:    AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegW      = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECUTER: w_aluop = 1'b1;
      EXECUTEI: begin
        ALUSrcB = SRCB_IMM;
        w_aluop = 1'b1;
      end
      ALUWB:    RegW = 1'b1;
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        w_branch  = 1'b1;
      end
      default: ;
    endcase
  end

  alu_dec u_alu_dec (
    .ALUOp      (w_aluop),
    .Funct      (Funct),
    .ALUControl (ALUControl),
    .FlagW      (FlagW)
  );

  // A write to R15 is a jump, so it must go through the PC-write path.
  assign PCS      = (RegW & (Rd == 4'hF)) | w_branch;
  assign ImmSrc   = Op;
  assign RegSrc   = {Op == OP_MEM, Op == OP_BR};
  assign StateDbg = r_state;

endmodule
